// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and sizing helpers for the SPI master arbiter.
// The package name is what the other files import.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LATCH,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD,
        RESP
    } arb_state_t;

    typedef logic [1:0] spi_mode_t;

    // Wide enough for CS_SETUP / CS_HOLD up to 15.
    localparam int PHASE_CNT_W = 4;

    function automatic int timeout_cnt_w(input int busy_timeout);
        return $clog2(busy_timeout + 1);
    endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Client request/response bus plus the spi_master control and chip-select signals.
// The arbiter uses the slave modport; client logic or a testbench uses the master modport.
interface spi_master_arbiter_if #(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_CNT_WIDTH = 16
);
    import spi_arb_pkg::*;

    logic [N_REQ-1:0]               req;
    logic [N_REQ*DATA_WIDTH-1:0]    req_data;
    logic [N_REQ*2-1:0]             req_mode;
    logic [N_REQ*CLK_CNT_WIDTH-1:0] req_div;
    logic [N_REQ-1:0]               ack;
    logic [N_REQ-1:0]               rsp_valid;
    logic                           rsp_err;
    logic [DATA_WIDTH-1:0]          rsp_data;

    logic [N_REQ-1:0]               cs_n;
    logic                           m_latch;
    logic [DATA_WIDTH-1:0]          m_data_in;
    spi_mode_t                      m_mode;
    logic [CLK_CNT_WIDTH-1:0]       m_sclk_div;
    logic [DATA_WIDTH-1:0]          m_data_out;
    logic                           m_idle;

    modport slave (
        input  req, req_data, req_mode, req_div, m_data_out, m_idle,
        output ack, rsp_valid, rsp_err, rsp_data,
               cs_n, m_latch, m_data_in, m_mode, m_sclk_div
    );

    modport master (
        output req, req_data, req_mode, req_div, m_data_out, m_idle,
        input  ack, rsp_valid, rsp_err, rsp_data,
               cs_n, m_latch, m_data_in, m_mode, m_sclk_div
    );

endinterface

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
// The pointer register itself lives in the parent.
module spi_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest set request overwrites last.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant_o[gi] = any_o && (idx_o == IW'(gi));
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one spi_master between N_REQ requesters, with per-requester
// active-low chip select, programmable setup/hold and a busy-start timeout.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CLK_CNT_WIDTH = 16,
    parameter int CS_SETUP      = 2,
    parameter int CS_HOLD       = 2,
    parameter int BUSY_TIMEOUT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_arbiter_if.slave bus
);

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W = timeout_cnt_w(BUSY_TIMEOUT);

    arb_state_t               state_q;
    logic [IW-1:0]            ptr_q;
    logic [IW-1:0]            ptr_d;
    logic [N_REQ-1:0]         owner_q;
    logic [N_REQ-1:0]         cs_n_q;
    logic [N_REQ-1:0]         ack_q;
    logic [N_REQ-1:0]         rsp_valid_q;
    logic                     rsp_err_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic [DATA_WIDTH-1:0]    cap_q;
    logic                     err_q;
    logic                     m_latch_q;
    logic [DATA_WIDTH-1:0]    m_data_in_q;
    spi_mode_t                m_mode_q;
    logic [CLK_CNT_WIDTH-1:0] m_sclk_div_q;
    logic [PHASE_CNT_W-1:0]   phase_cnt_q;
    logic [TO_W-1:0]          to_cnt_q;

    logic [N_REQ-1:0]         win_grant;
    logic [IW-1:0]            win_idx;
    logic                     win_any;

    logic [DATA_WIDTH-1:0]    data_arr [N_REQ];
    spi_mode_t                mode_arr [N_REQ];
    logic [CLK_CNT_WIDTH-1:0] div_arr  [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign mode_arr[gi] = bus.req_mode[gi*2 +: 2];
        assign div_arr[gi]  = bus.req_div[gi*CLK_CNT_WIDTH +: CLK_CNT_WIDTH];
    end

    spi_rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    always_comb begin
        ptr_d = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cs_n_q       <= '1;
            ack_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            cap_q        <= '0;
            err_q        <= 1'b0;
            m_latch_q    <= 1'b0;
            m_data_in_q  <= '0;
            m_mode_q     <= '0;
            m_sclk_div_q <= '0;
            phase_cnt_q  <= '0;
            to_cnt_q     <= '0;
        end else begin
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            m_latch_q   <= 1'b0;
            case (state_q)
                // A master still shifting from before a reset must finish before any grant.
                IDLE: begin
                    if (bus.m_idle && win_any) begin
                        ack_q        <= win_grant;
                        owner_q      <= win_grant;
                        cs_n_q       <= ~win_grant;
                        m_data_in_q  <= data_arr[win_idx];
                        m_mode_q     <= mode_arr[win_idx];
                        m_sclk_div_q <= div_arr[win_idx];
                        ptr_q        <= ptr_d;
                        err_q        <= 1'b0;
                        phase_cnt_q  <= '0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt_q == PHASE_CNT_W'(CS_SETUP - 1)) begin
                        phase_cnt_q <= '0;
                        state_q     <= LATCH;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 1'b1;
                    end
                end
                LATCH: begin
                    m_latch_q <= 1'b1;
                    to_cnt_q  <= '0;
                    state_q   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.m_idle) begin
                        state_q <= WAIT_DONE;
                    end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                        err_q       <= 1'b1;
                        phase_cnt_q <= '0;
                        state_q     <= HOLD;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.m_idle) begin
                        cap_q       <= bus.m_data_out;
                        phase_cnt_q <= '0;
                        state_q     <= HOLD;
                    end
                end
                // Response is launched together with cs_n release so it is visible in RESP.
                HOLD: begin
                    if (phase_cnt_q == PHASE_CNT_W'(CS_HOLD - 1)) begin
                        cs_n_q      <= '1;
                        rsp_valid_q <= owner_q;
                        rsp_err_q   <= err_q;
                        if (!err_q) begin
                            rsp_data_q <= cap_q;
                        end
                        state_q <= RESP;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.m_latch    = m_latch_q;
    assign bus.m_data_in  = m_data_in_q;
    assign bus.m_mode     = m_mode_q;
    assign bus.m_sclk_div = m_sclk_div_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback spi_master stub.
// The stub returns the latched tx word after stub_len busy cycles.
module tb_spi_master_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    spi_master_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8), .CLK_CNT_WIDTH(16)) bus ();

    spi_master_arbiter #(
        .N_REQ(4), .DATA_WIDTH(8), .CLK_CNT_WIDTH(16),
        .CS_SETUP(2), .CS_HOLD(2), .BUSY_TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // spi_master stub: goes busy the cycle after latch, idle again after stub_len cycles.
    logic       stub_busy  = 1'b0;
    int         stub_cnt   = 0;
    logic [7:0] stub_sr    = 8'h00;
    logic [7:0] stub_out   = 8'h00;
    bit         stub_en    = 1'b1;
    int         stub_len   = 6;
    bit         force_busy = 1'b0;

    always @(posedge clk) begin
        if (!stub_busy) begin
            if (stub_en && bus.m_latch) begin
                stub_busy <= 1'b1;
                stub_cnt  <= stub_len;
                stub_sr   <= bus.m_data_in;
            end
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else begin
            stub_busy <= 1'b0;
            stub_out  <= stub_sr;
        end
    end

    assign bus.m_idle     = ~stub_busy & ~force_busy;
    assign bus.m_data_out = stub_out;

    // Monitors: mode may only change while all cs_n are high; cs_n one-hot-low with a high gap.
    bit         mon_en    = 1'b1;
    int         mode_viol = 0;
    int         cs_viol   = 0;
    logic [1:0] prev_mode = 2'b00;
    logic [3:0] prev_cs   = 4'hF;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.m_mode !== prev_mode && prev_cs !== 4'hF) mode_viol++;
            if (bus.cs_n !== 4'hF && $countones(~bus.cs_n) != 1) cs_viol++;
            if (prev_cs !== 4'hF && bus.cs_n !== 4'hF && bus.cs_n !== prev_cs) cs_viol++;
        end
        prev_mode = bus.m_mode;
        prev_cs   = bus.cs_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [7:0] d, input logic [1:0] m, input logic [15:0] dv);
        bus.req_data[idx*8 +: 8]  = d;
        bus.req_mode[idx*2 +: 2]  = m;
        bus.req_div[idx*16 +: 16] = dv;
        bus.req[idx]              = 1'b1;
    endtask

    // Follows one transaction from ack to rsp_valid, checking the owner's signals throughout.
    task automatic serve(input int idx, input logic [7:0] d, input logic [1:0] m, input logic [15:0] dv,
                         input logic exp_err, input logic [7:0] exp_rdata, input bit drop,
                         output int wait_cyc);
        int         n;
        int         since_rise;
        bit         stable_ok;
        logic       prev_idle;
        logic [3:0] ack1;
        logic       latch1;
        logic [3:0] low;
        low = ~(4'b0001 << idx);
        n = 0;
        do begin tick(); n++; end while (bus.ack === 4'h0 && n < 60);
        wait_cyc = n;
        check($sformatf("ack[%0d]", idx), 32'(bus.ack), 32'(1 << idx));
        check("cs_n_grant", 32'(bus.cs_n), 32'(low));
        check("m_data_in", 32'(bus.m_data_in), 32'(d));
        check("m_mode", 32'(bus.m_mode), 32'(m));
        check("m_sclk_div", 32'(bus.m_sclk_div), 32'(dv));
        if (drop) bus.req[idx] = 1'b0;
        stable_ok = 1'b1;
        ack1 = 4'h0;
        n = 0;
        do begin
            tick(); n++;
            if (n == 1) ack1 = bus.ack;
            if (bus.cs_n !== low || bus.m_mode !== m || bus.m_data_in !== d || bus.m_sclk_div !== dv)
                stable_ok = 1'b0;
        end while (!bus.m_latch && n < 40);
        check("ack_one_cycle", 32'(ack1), 32'h0);
        check("ack_to_latch", 32'(n), 32'd3);
        n = 0;
        since_rise = -1;
        latch1 = 1'b1;
        prev_idle = bus.m_idle;
        do begin
            tick(); n++;
            if (n == 1) latch1 = bus.m_latch;
            if (bus.m_idle && !prev_idle) since_rise = 0;
            else if (since_rise >= 0) since_rise++;
            prev_idle = bus.m_idle;
            if (!bus.rsp_valid[idx] && (bus.cs_n !== low || bus.m_mode !== m || bus.m_data_in !== d))
                stable_ok = 1'b0;
        end while (bus.rsp_valid === 4'h0 && n < 200);
        check("latch_one_cycle", 32'(latch1), 32'h0);
        check("owner_stable", 32'(stable_ok), 32'h1);
        check($sformatf("rsp_valid[%0d]", idx), 32'(bus.rsp_valid), 32'(1 << idx));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_data", 32'(bus.rsp_data), 32'(exp_rdata));
        check("cs_n_released", 32'(bus.cs_n), 32'hF);
        if (exp_err) check("latch_to_timeout_rsp", 32'(n), 32'd10);
        else         check("idle_rise_to_rsp", 32'(since_rise), 32'd3);
        $display("txn req=%0d tx=%02h mode=%0d rsp=%02h err=%0d", idx, d, m, bus.rsp_data, bus.rsp_err);
    endtask

    initial begin
        int         w;
        int         n;
        bit         bad;
        logic [7:0] t3_data [3];
        t3_data[0] = 8'hF0;
        t3_data[1] = 8'h0F;
        t3_data[2] = 8'h33;

        bus.req      = '0;
        bus.req_data = '0;
        bus.req_mode = '0;
        bus.req_div  = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_cs_n", 32'(bus.cs_n), 32'hF);
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        check("rst_m_latch", 32'(bus.m_latch), 32'h0);
        check("rst_m_data_in", 32'(bus.m_data_in), 32'h0);
        check("rst_m_mode", 32'(bus.m_mode), 32'h0);
        check("rst_m_sclk_div", 32'(bus.m_sclk_div), 32'h0);
        rst = 1'b0;
        tick();

        // All four requesting: grants 0,1,2,3 with each requester's own data and mode.
        set_req(0, 8'h11, 2'd0, 16'd2);
        set_req(1, 8'h22, 2'd1, 16'd6);
        set_req(2, 8'h33, 2'd2, 16'd10);
        set_req(3, 8'h44, 2'd3, 16'd14);
        serve(0, 8'h11, 2'd0, 16'd2,  1'b0, 8'h11, 1'b1, w);
        serve(1, 8'h22, 2'd1, 16'd6,  1'b0, 8'h22, 1'b1, w);
        serve(2, 8'h33, 2'd2, 16'd10, 1'b0, 8'h33, 1'b1, w);
        serve(3, 8'h44, 2'd3, 16'd14, 1'b0, 8'h44, 1'b1, w);

        // Single requester 2, loopback, req-to-ack latency of one cycle.
        tick();
        set_req(2, 8'hA5, 2'd0, 16'd8);
        serve(2, 8'hA5, 2'd0, 16'd8, 1'b0, 8'hA5, 1'b1, w);
        check("req_to_ack", 32'(w), 32'd1);

        // Requester 1 held high through three back-to-back transactions.
        tick();
        set_req(1, t3_data[0], 2'd1, 16'd16);
        for (int i = 0; i < 3; i++) begin
            serve(1, t3_data[i], 2'd1, 16'd16, 1'b0, t3_data[i], 1'b0, w);
            if (i < 2) bus.req_data[8 +: 8] = t3_data[i+1];
            else       bus.req[1] = 1'b0;
        end

        // Master never goes busy: timeout error, rsp_data keeps the last good word.
        tick();
        stub_en = 1'b0;
        set_req(0, 8'h5A, 2'd2, 16'd4);
        serve(0, 8'h5A, 2'd2, 16'd4, 1'b1, 8'h33, 1'b1, w);
        stub_en = 1'b1;
        tick();
        set_req(3, 8'hC3, 2'd3, 16'd2);
        serve(3, 8'hC3, 2'd3, 16'd2, 1'b0, 8'hC3, 1'b1, w);

        // Reset while the master is shifting; pending req 2 waits for m_idle.
        tick();
        stub_len = 20;
        set_req(1, 8'h77, 2'd1, 16'd3);
        n = 0;
        do begin tick(); n++; end while (bus.ack === 4'h0 && n < 40);
        check("t5_ack[1]", 32'(bus.ack), 32'h2);
        bus.req[1] = 1'b0;
        set_req(2, 8'h99, 2'd2, 16'd5);
        n = 0;
        do begin tick(); n++; end while (bus.m_idle && n < 20);
        check("t5_master_busy", 32'(bus.m_idle), 32'h0);
        tick();
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_rst_cs_n", 32'(bus.cs_n), 32'hF);
        check("t5_rst_m_latch", 32'(bus.m_latch), 32'h0);
        check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("t5_rst_rsp_data", 32'(bus.rsp_data), 32'h0);
        rst = 1'b0;
        stub_len = 6;
        bad = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            if (n == 1) mon_en = 1'b1;
            if (bus.ack !== 4'h0 || bus.rsp_valid !== 4'h0) bad = 1'b1;
        end while (!bus.m_idle && n < 40);
        check("t5_no_grant_while_busy", 32'(bad), 32'h0);
        check("t5_idle_returns", 32'(bus.m_idle), 32'h1);
        serve(2, 8'h99, 2'd2, 16'd5, 1'b0, 8'h99, 1'b1, w);
        check("t5_req_to_ack", 32'(w), 32'd1);

        // Req 0 withdrawn before ack while req 3 waits; m_idle low in IDLE blocks grants.
        tick();
        force_busy = 1'b1;
        set_req(0, 8'hE1, 2'd1, 16'd7);
        set_req(3, 8'h3C, 2'd0, 16'd9);
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (bus.ack !== 4'h0 || bus.cs_n !== 4'hF) bad = 1'b1;
        end
        check("t6_no_grant_idle_low", 32'(bad), 32'h0);
        bus.req[0] = 1'b0;
        tick();
        force_busy = 1'b0;
        serve(3, 8'h3C, 2'd0, 16'd9, 1'b0, 8'h3C, 1'b1, w);
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (bus.ack !== 4'h0 || bus.cs_n !== 4'hF) bad = 1'b1;
        end
        check("t6_withdrawn_not_served", 32'(bad), 32'h0);

        check("mode_change_only_cs_high", 32'(mode_viol), 32'h0);
        check("cs_n_onehot_and_gap", 32'(cs_viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Shares one spi_master instance between N_REQ requesters using round-robin arbitration. Per transaction it:
- captures the winning requester's data, mode and sclk divider;
- drives that requester's active-low chip select with programmable setup and hold;
- pulses latch and tracks the master's idle flag through busy and done;
- returns the received byte to the owner.
It sits between client logic and spi_master; the master's spi_intf goes straight to pins, with cs_n[] from this block alongside.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, transfer width; matches spi_master
CLK_CNT_WIDTH, 16, width of sclk divider; matches spi_master
CS_SETUP, 2, clk cycles from cs_n low to latch pulse (1..15)
CS_HOLD, 2, clk cycles from master idle to cs_n high (1..15)
BUSY_TIMEOUT, 8, max clk cycles waiting for master idle to fall after latch

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  request per requester; level, held until ack
req_data  in  N_REQ*DATA_WIDTH  tx word per requester, slice i
req_mode  in  N_REQ*2  SPI mode 0-3 per requester
req_div  in  N_REQ*CLK_CNT_WIDTH  sclk divider per requester
ack  out  N_REQ  one-cycle pulse: request captured
rsp_valid  out  N_REQ  one-cycle pulse: transaction finished for requester i
rsp_err  out  1  qualifies rsp_valid; 1 = master never went busy (timeout)
rsp_data  out  DATA_WIDTH  received word; held until next rsp_valid
cs_n  out  N_REQ  chip selects, active low, one-hot-low or all high
m_latch  out  1  to spi_master latch
m_data_in  out  DATA_WIDTH  to spi_master data_in
m_mode  out  2  to spi_master mode
m_sclk_div  out  CLK_CNT_WIDTH  to spi_master sclk_div
m_data_out  in  DATA_WIDTH  from spi_master data_out
m_idle  in  1  from spi_master idle

Behaviour:
- Reset values: state IDLE, RR pointer 0, cs_n all 1. The following outputs are 0: ack, rsp_valid, rsp_err, m_latch, rsp_data, m_data_in, m_mode, m_sclk_div.
- States:
  - IDLE: grant only when m_idle=1 and any req=1. The winner is the first set req at or after the pointer, wrapping. On the grant edge:
    - ack[w]=1 for one cycle;
    - m_data_in, m_mode and m_sclk_div are loaded from slice w;
    - cs_n[w]=0;
    - pointer = w+1 mod N_REQ;
    - go to SETUP.
  - SETUP: count CS_SETUP cycles, then LATCH.
  - LATCH: m_latch=1 for exactly one cycle, then WAIT_BUSY.
  - WAIT_BUSY: m_idle=0 -> WAIT_DONE. If BUSY_TIMEOUT cycles pass with m_idle still 1, set error flag and go to HOLD.
  - WAIT_DONE: m_idle=1 -> capture m_data_out, go to HOLD.
  - HOLD: count CS_HOLD cycles, then cs_n all 1 and go to RESP.
  - RESP: rsp_valid[w]=1 for one cycle, rsp_err=error flag, rsp_data=captured word (unchanged on error). Go to IDLE.
- m_mode, m_sclk_div and m_data_in are stable from grant to RESP. Mode never changes while any cs_n is low.
- Minimum gap: cs_n is high at least 1 cycle between transactions, since RESP and IDLE both have cs_n high.
- Requester contract: req may stay high for back-to-back use. The requester must hold data/mode/div stable until ack. Dropping req before ack withdraws the request.
- Fairness: with all req high, grants go 0,1,2,3,0,... A sole requester is re-granted every transaction.
- Requests appearing mid-transaction are ignored until IDLE.
- Reset mid-operation: all state returns to reset values immediately, with no rsp_valid. The master may still be shifting, so IDLE withholds grant until m_idle=1.
- m_idle already 0 in IDLE (external disturbance): no grant.
- Latency:
  - req high to ack: 1 cycle, when in IDLE, winning and m_idle=1.
  - ack to m_latch: CS_SETUP+1 cycles.
  - m_idle rise to rsp_valid: CS_HOLD+1 cycles.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum arb_state_t {IDLE, SETUP, LATCH, WAIT_BUSY, WAIT_DONE, HOLD, RESP};
  - spi_mode_t (logic [1:0]);
  - localparam for setup/hold/timeout counter width = 4 bits, timeout counter sized by $clog2(BUSY_TIMEOUT+1).
- Sub-module spi_rr_arbiter (parameter N):
  - combinational pick from req and pointer;
  - outputs grant one-hot plus index and any;
  - pointer register stays in the parent.

Test Plan:
1. Single requester: req[2]=1, data 8'hA5, mode 0, div 8, MISO looped to MOSI -> ack[2] one cycle; cs_n=4'b1011 for the whole transfer; latch 3 cycles after ack; rsp_valid[2] with rsp_data=8'hA5, rsp_err=0.
2. All four requesting with data 8'h11/22/33/44 and modes 0-3 -> grants in order 0,1,2,3. Each rsp_data equals its own data. Mode changes only while cs_n=4'b1111.
3. Requester 1 holds req through three transactions (8'hF0, 8'h0F, 8'h33) -> three acks and three responses in order. cs_n goes high for at least 1 cycle between each.
4. Master stubbed with m_idle tied 1 -> after BUSY_TIMEOUT=8 cycles, cs_n releases after CS_HOLD. rsp_valid with rsp_err=1; next request is still served.
5. Assert rst during WAIT_DONE -> next cycle cs_n=all 1, m_latch=0, no rsp_valid. A pending req is not acked until m_idle returns 1.
6. req[0] raised then dropped before ack while req[3] is high -> only ack[3] and rsp_valid[3]; no activity on cs_n[0].
